// File: rtl/pe_pkg.sv
// Shared helpers for the systolic PE family:
// saturation limits and multiply-stage constants.
package pe_pkg;

  localparam int MUL_PIPE_OFF = 0;
  localparam int MUL_PIPE_ON  = 1;
  localparam int MAX_W        = 64;

  typedef logic [MAX_W-1:0] wide_t;

  function automatic wide_t sat_max(
    input bit sgn,
    input int w
  );
    if (sgn) return (wide_t'(1) << (w - 1)) - wide_t'(1);
    return (wide_t'(1) << w) - wide_t'(1);
  endfunction

  function automatic wide_t sat_min(
    input bit sgn,
    input int w
  );
    if (sgn) return ~sat_max(1'b1, w);
    return '0;
  endfunction

endpackage

// File: rtl/pe_sat_add.sv
// Combinational accumulate: wide add, overflow
// detect, and optional clamp to the type limits.
module pe_sat_add
  import pe_pkg::*;
#(
  parameter int ACC_W    = 32,
  parameter int SIGNED   = 1,
  parameter int SATURATE = 1
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

  localparam logic [ACC_W-1:0] HI =
    ACC_W'(sat_max(SIGNED != 0, ACC_W));
  localparam logic [ACC_W-1:0] LO =
    ACC_W'(sat_min(SIGNED != 0, ACC_W));

  logic [ACC_W:0] raw;

  always_comb begin
    raw = {1'b0, a} + {1'b0, b};
    sum = raw[ACC_W-1:0];
    if (SIGNED != 0) begin
      ovf = (a[ACC_W-1] == b[ACC_W-1]) &&
            (raw[ACC_W-1] != a[ACC_W-1]);
    end else begin
      ovf = raw[ACC_W];
    end
    // signed overflow direction follows the operand sign
    if (ovf && SATURATE != 0) begin
      if (SIGNED != 0 && a[ACC_W-1]) sum = LO;
      else sum = HI;
    end
  end

endmodule

// File: rtl/mac_pe_db.sv
// Weight-stationary systolic MAC cell with a shadow
// weight chain so the next tile loads during compute.
module mac_pe_db
  import pe_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int WT_W     = 8,
  parameter int ACC_W    = 32,
  parameter int SIGNED   = 1,
  parameter int SATURATE = 1,
  parameter int MUL_PIPE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wt_shift,
  input  logic [WT_W-1:0]   wt_in,
  output logic [WT_W-1:0]   wt_out,
  input  logic              wt_swap,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ACC_W-1:0]  acc_in,
  output logic              valid_out,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid_out,
  output logic [ACC_W-1:0]  acc_out,
  output logic              ovf,
  input  logic              ovf_clr
);

  localparam int PIPE = (MUL_PIPE == MUL_PIPE_ON) ?
    MUL_PIPE_ON : MUL_PIPE_OFF;

  typedef logic [ACC_W-1:0]  acc_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [WT_W-1:0]   wt_t;

  wt_t   sh_w_q, sh_w_d;
  wt_t   act_w_q, act_w_d;
  data_t data_q, data_d;
  logic  dvalid_q, dvalid_d;
  acc_t  acc_q, acc_d;
  logic  valid_q, valid_d;
  logic  ovf_q, ovf_d;
  acc_t  p_prod_q, p_prod_d;
  acc_t  p_acc_q, p_acc_d;
  logic  p_valid_q, p_valid_d;

  logic signed [DATA_W:0] d_x;
  logic signed [WT_W:0]   w_x;
  acc_t prod, s_prod, s_acc, add_sum;
  logic s_valid, add_ovf;

  always_comb begin
    d_x = {SIGNED != 0 && data_in[DATA_W-1], data_in};
    w_x = {SIGNED != 0 && act_w_q[WT_W-1], act_w_q};
    prod = ACC_W'(d_x) * ACC_W'(w_x);
    if (PIPE == MUL_PIPE_ON) begin
      s_prod  = p_prod_q;
      s_acc   = p_acc_q;
      s_valid = p_valid_q;
    end else begin
      s_prod  = prod;
      s_acc   = acc_in;
      s_valid = valid_in;
    end
  end

  pe_sat_add #(
    .ACC_W    (ACC_W),
    .SIGNED   (SIGNED),
    .SATURATE (SATURATE)
  ) u_add (
    .a   (s_acc),
    .b   (s_prod),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  always_comb begin
    sh_w_d    = wt_shift ? wt_in : sh_w_q;
    // swap commits the pre-shift shadow value
    act_w_d   = wt_swap ? sh_w_q : act_w_q;
    data_d    = data_in;
    dvalid_d  = valid_in;
    p_prod_d  = prod;
    p_acc_d   = acc_in;
    p_valid_d = valid_in;
    valid_d   = s_valid;
    acc_d     = s_valid ? add_sum : s_acc;
    ovf_d     = (s_valid && add_ovf) ||
                (ovf_q && !ovf_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_w_q    <= '0;
      act_w_q   <= '0;
      data_q    <= '0;
      dvalid_q  <= 1'b0;
      acc_q     <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
      p_prod_q  <= '0;
      p_acc_q   <= '0;
      p_valid_q <= 1'b0;
    end else begin
      sh_w_q    <= sh_w_d;
      act_w_q   <= act_w_d;
      data_q    <= data_d;
      dvalid_q  <= dvalid_d;
      acc_q     <= acc_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
      p_prod_q  <= p_prod_d;
      p_acc_q   <= p_acc_d;
      p_valid_q <= p_valid_d;
    end
  end

  assign wt_out         = sh_w_q;
  assign data_out       = data_q;
  assign data_valid_out = dvalid_q;
  assign acc_out        = acc_q;
  assign valid_out      = valid_q;
  assign ovf            = ovf_q;

endmodule

// File: tb/tb_mac_pe_db.sv
// Bench for mac_pe_db: five parameter variants share
// one stimulus stream against an arithmetic model.
module tb_mac_pe_db;

  logic clk = 1'b0;
  logic rst_n;
  logic wt_shift, wt_swap, valid_in, ovf_clr;
  logic [7:0] wt_in, data_in;
  logic [31:0] acc32;
  logic [15:0] acc16;

  logic [7:0] wt_o [5];
  logic [7:0] dat_o [5];
  logic dv_o [5];
  logic vo [5];
  logic ov_o [5];
  logic [31:0] acc_o0, acc_o3;
  logic [15:0] acc_o1, acc_o2, acc_o4;
  longint g_acc [5];

  assign g_acc[0] = longint'(acc_o0);
  assign g_acc[1] = longint'(acc_o1);
  assign g_acc[2] = longint'(acc_o2);
  assign g_acc[3] = longint'(acc_o3);
  assign g_acc[4] = longint'(acc_o4);

  int accw [5] = '{32, 16, 16, 32, 16};
  bit sg [5]   = '{1, 1, 1, 1, 0};
  bit st [5]   = '{1, 1, 0, 1, 1};

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mac_pe_db #(.ACC_W(32), .SATURATE(1), .MUL_PIPE(0)) d0 (
    .clk(clk), .rst_n(rst_n), .wt_shift(wt_shift),
    .wt_in(wt_in), .wt_out(wt_o[0]), .wt_swap(wt_swap),
    .valid_in(valid_in), .data_in(data_in),
    .acc_in(acc32), .valid_out(vo[0]),
    .data_out(dat_o[0]), .data_valid_out(dv_o[0]),
    .acc_out(acc_o0), .ovf(ov_o[0]), .ovf_clr(ovf_clr));

  mac_pe_db #(.ACC_W(16), .SATURATE(1), .MUL_PIPE(0)) d1 (
    .clk(clk), .rst_n(rst_n), .wt_shift(wt_shift),
    .wt_in(wt_in), .wt_out(wt_o[1]), .wt_swap(wt_swap),
    .valid_in(valid_in), .data_in(data_in),
    .acc_in(acc16), .valid_out(vo[1]),
    .data_out(dat_o[1]), .data_valid_out(dv_o[1]),
    .acc_out(acc_o1), .ovf(ov_o[1]), .ovf_clr(ovf_clr));

  mac_pe_db #(.ACC_W(16), .SATURATE(0), .MUL_PIPE(0)) d2 (
    .clk(clk), .rst_n(rst_n), .wt_shift(wt_shift),
    .wt_in(wt_in), .wt_out(wt_o[2]), .wt_swap(wt_swap),
    .valid_in(valid_in), .data_in(data_in),
    .acc_in(acc16), .valid_out(vo[2]),
    .data_out(dat_o[2]), .data_valid_out(dv_o[2]),
    .acc_out(acc_o2), .ovf(ov_o[2]), .ovf_clr(ovf_clr));

  mac_pe_db #(.ACC_W(32), .SATURATE(1), .MUL_PIPE(1)) d3 (
    .clk(clk), .rst_n(rst_n), .wt_shift(wt_shift),
    .wt_in(wt_in), .wt_out(wt_o[3]), .wt_swap(wt_swap),
    .valid_in(valid_in), .data_in(data_in),
    .acc_in(acc32), .valid_out(vo[3]),
    .data_out(dat_o[3]), .data_valid_out(dv_o[3]),
    .acc_out(acc_o3), .ovf(ov_o[3]), .ovf_clr(ovf_clr));

  mac_pe_db #(.ACC_W(16), .SIGNED(0), .SATURATE(1)) d4 (
    .clk(clk), .rst_n(rst_n), .wt_shift(wt_shift),
    .wt_in(wt_in), .wt_out(wt_o[4]), .wt_swap(wt_swap),
    .valid_in(valid_in), .data_in(data_in),
    .acc_in(acc16), .valid_out(vo[4]),
    .data_out(dat_o[4]), .data_valid_out(dv_o[4]),
    .acc_out(acc_o4), .ovf(ov_o[4]), .ovf_clr(ovf_clr));

  // reference model state
  logic [7:0] m_sh, m_act, e_dat;
  bit e_dv;
  longint e_acc [5];
  bit e_valid [5];
  bit e_ovf [5];
  longint p_res, p_acc;
  bit p_ov, p_valid;

  function automatic longint mac(
    input longint acc_bits, input int w,
    input bit sgn, input bit sat,
    input logic [7:0] d, input logic [7:0] wt,
    output bit ov);
    longint m, a, dv, wv, s, lo, hi;
    m = longint'(1) << w;
    a = acc_bits;
    if (sgn && acc_bits >= m / 2) a = acc_bits - m;
    dv = sgn ? longint'($signed(d)) : longint'(d);
    wv = sgn ? longint'($signed(wt)) : longint'(wt);
    s = a + dv * wv;
    lo = sgn ? -(m / 2) : 0;
    hi = sgn ? (m / 2 - 1) : (m - 1);
    ov = (s < lo) || (s > hi);
    if (ov && sat) s = (s < lo) ? lo : hi;
    return s & (m - 1);
  endfunction

  function automatic longint acc_for(input int i);
    return (accw[i] == 32) ? longint'(acc32) : longint'(acc16);
  endfunction

  task automatic model_reset();
    m_sh = 0; m_act = 0; e_dat = 0; e_dv = 0;
    p_res = 0; p_acc = 0; p_ov = 0; p_valid = 0;
    for (int i = 0; i < 5; i++) begin
      e_acc[i] = 0; e_valid[i] = 0; e_ovf[i] = 0;
    end
  endtask

  task automatic model_edge();
    bit ov;
    longint r;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) continue;
      if (valid_in) begin
        r = mac(acc_for(i), accw[i], sg[i], st[i],
                data_in, m_act, ov);
        e_acc[i] = r;
        e_valid[i] = 1;
        e_ovf[i] = ov || (e_ovf[i] && !ovf_clr);
      end else begin
        e_acc[i] = acc_for(i);
        e_valid[i] = 0;
        e_ovf[i] = e_ovf[i] && !ovf_clr;
      end
    end
    e_acc[3] = p_valid ? p_res : p_acc;
    e_valid[3] = p_valid;
    e_ovf[3] = (p_valid && p_ov) || (e_ovf[3] && !ovf_clr);
    p_res = mac(longint'(acc32), 32, 1, 1, data_in, m_act, ov);
    p_ov = ov;
    p_acc = longint'(acc32);
    p_valid = valid_in;
    e_dat = data_in;
    e_dv = valid_in;
    if (wt_swap) m_act = m_sh;
    if (wt_shift) m_sh = wt_in;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    wt_shift = 0; wt_swap = 0; valid_in = 0;
    ovf_clr = 0; wt_in = 0; data_in = 0;
    acc32 = 0; acc16 = 0;
  endtask

  task automatic load_act(input logic [7:0] w);
    wt_in = w; wt_shift = 1; tick();
    wt_shift = 0; wt_swap = 1; tick();
    wt_swap = 0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    model_reset();
    #12;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (g_acc[i] !== 0) begin
        bad++;
        $display("FAIL reset_acc inst%0d got=%0h want=0",
                 i, g_acc[i]);
      end
      total++;
      if ({vo[i], ov_o[i], dv_o[i], dat_o[i], wt_o[i]}
          !== 19'd0) begin
        bad++;
        $display("FAIL reset_flags inst%0d v=%b o=%b dv=%b d=%h w=%h want all 0",
                 i, vo[i], ov_o[i], dv_o[i], dat_o[i], wt_o[i]);
      end
    end
    #11 rst_n = 1;
    tick();
  endtask

  task automatic test_basic_mac();
    load_act(8'd3);
    valid_in = 1; data_in = 8'hFC;
    acc32 = 10; acc16 = 10;
    tick();
    total++;
    if (acc_o0 !== 32'hFFFF_FFFE || vo[0] !== 1'b1) begin
      bad++;
      $display("FAIL basic_mac got=%h/%b want=fffffffe/1",
               acc_o0, vo[0]);
    end
    total++;
    if (dat_o[0] !== 8'hFC || dv_o[0] !== 1'b1) begin
      bad++;
      $display("FAIL basic_fwd got=%h/%b want=fc/1",
               dat_o[0], dv_o[0]);
    end
    total++;
    if (acc_o1 !== 16'hFFFE) begin
      bad++;
      $display("FAIL basic_mac16 got=%h want=fffe", acc_o1);
    end
    idle();
    tick();
    total++;
    if (acc_o3 !== 32'hFFFF_FFFE || vo[3] !== 1'b1) begin
      bad++;
      $display("FAIL basic_pipe got=%h/%b want=fffffffe/1",
               acc_o3, vo[3]);
    end
  endtask

  task automatic test_double_buffer();
    longint exp_v;
    int dv, av;
    load_act(8'd2);
    for (int j = 0; j < 6; j++) begin
      dv = $urandom_range(0, 50);
      av = $urandom_range(0, 1000);
      valid_in = 1; data_in = 8'(dv);
      acc32 = 32'(av); acc16 = 16'(av);
      wt_in = 8'd5; wt_shift = 1;
      wt_swap = (j == 3);
      exp_v = av + dv * ((j <= 3) ? 2 : 5);
      tick();
      total++;
      if (g_acc[0] !== exp_v || vo[0] !== 1'b1) begin
        bad++;
        $display("FAIL dbuf s%0d got=%0d/%b want=%0d/1",
                 j, g_acc[0], vo[0], exp_v);
      end
      total++;
      if (g_acc[3] !== e_acc[3] || vo[3] !== e_valid[3]) begin
        bad++;
        $display("FAIL dbuf_pipe s%0d got=%0d/%b want=%0d/%b",
                 j, g_acc[3], vo[3], e_acc[3], e_valid[3]);
      end
    end
    idle();
    tick();
  endtask

  task automatic test_saturation();
    load_act(8'd1);
    valid_in = 1; data_in = 8'd10;
    acc16 = 16'd32760; acc32 = 32'd32760;
    tick();
    total++;
    if (acc_o1 !== 16'h7FFF || ov_o[1] !== 1'b1) begin
      bad++;
      $display("FAIL sat_clamp got=%h/%b want=7fff/1",
               acc_o1, ov_o[1]);
    end
    total++;
    if (acc_o2 !== 16'h8002 || ov_o[2] !== 1'b1) begin
      bad++;
      $display("FAIL sat_wrap got=%h/%b want=8002/1",
               acc_o2, ov_o[2]);
    end
    total++;
    if (acc_o4 !== 16'd32770 || ov_o[4] !== 1'b0) begin
      bad++;
      $display("FAIL sat_unsigned got=%h/%b want=8002/0",
               acc_o4, ov_o[4]);
    end
    idle();
  endtask

  task automatic test_ovf_priority();
    ovf_clr = 1;
    tick();
    total++;
    if (ov_o[1] !== 1'b0 || ov_o[2] !== 1'b0) begin
      bad++;
      $display("FAIL ovf_clear got=%b%b want=00",
               ov_o[1], ov_o[2]);
    end
    valid_in = 1; data_in = 8'd10;
    acc16 = 16'd32760; ovf_clr = 1;
    tick();
    total++;
    if (ov_o[1] !== 1'b1 || ov_o[2] !== 1'b1) begin
      bad++;
      $display("FAIL ovf_set_wins got=%b%b want=11",
               ov_o[1], ov_o[2]);
    end
    idle();
    tick();
    total++;
    if (ov_o[1] !== 1'b1) begin
      bad++;
      $display("FAIL ovf_sticky got=%b want=1", ov_o[1]);
    end
  endtask

  task automatic test_pipe_gating();
    acc32 = 32'd7;
    tick();
    acc32 = 32'd100;
    tick();
    total++;
    if (acc_o3 !== 32'd7 || vo[3] !== 1'b0) begin
      bad++;
      $display("FAIL pipe_gate got=%0d/%b want=7/0",
               acc_o3, vo[3]);
    end
    valid_in = 1; data_in = 8'd5; acc32 = 32'd20;
    tick();
    idle();
    total++;
    if (acc_o3 !== 32'd100 || vo[3] !== 1'b0) begin
      bad++;
      $display("FAIL pipe_gate2 got=%0d/%b want=100/0",
               acc_o3, vo[3]);
    end
    tick();
    total++;
    if (acc_o3 !== 32'd25 || vo[3] !== 1'b1) begin
      bad++;
      $display("FAIL pipe_valid got=%0d/%b want=25/1",
               acc_o3, vo[3]);
    end
  endtask

  task automatic rand_inputs();
    int mode;
    valid_in = ($urandom_range(0, 3) != 0);
    wt_shift = $urandom_range(0, 1);
    wt_swap = ($urandom_range(0, 3) == 0);
    ovf_clr = ($urandom_range(0, 7) == 0);
    wt_in = 8'($urandom);
    data_in = 8'($urandom);
    mode = $urandom_range(0, 3);
    unique case (mode)
      0: begin acc16 = 16'($urandom); acc32 = $urandom; end
      1: begin
        acc16 = 16'h7F00 + 16'($urandom_range(0, 255));
        acc32 = 32'h7FFF_C000 + $urandom_range(0, 32767);
      end
      2: begin
        acc16 = 16'h8000 + 16'($urandom_range(0, 255));
        acc32 = 32'h8000_0000 + $urandom_range(0, 32767);
      end
      default: begin
        acc16 = 16'hC000 + 16'($urandom_range(0, 16383));
        acc32 = 32'hFFFF_8000 + $urandom_range(0, 32767);
      end
    endcase
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      rand_inputs();
      tick();
      for (int i = 0; i < 5; i++) begin
        total++;
        if (g_acc[i] !== e_acc[i] || vo[i] !== e_valid[i] ||
            ov_o[i] !== e_ovf[i]) begin
          bad++;
          $display("FAIL rand_acc c%0d inst%0d got=%0h/%b/%b want=%0h/%b/%b",
                   n, i, g_acc[i], vo[i], ov_o[i],
                   e_acc[i], e_valid[i], e_ovf[i]);
        end
        total++;
        if (dat_o[i] !== e_dat || dv_o[i] !== e_dv ||
            wt_o[i] !== m_sh) begin
          bad++;
          $display("FAIL rand_fwd c%0d inst%0d got=%h/%b/%h want=%h/%b/%h",
                   n, i, dat_o[i], dv_o[i], wt_o[i],
                   e_dat, e_dv, m_sh);
        end
      end
    end
    idle();
  endtask

  task automatic test_async_reset();
    load_act(8'd7);
    for (int n = 0; n < 4; n++) begin
      rand_inputs();
      valid_in = 1;
      tick();
    end
    #2 rst_n = 0;
    #1;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      total++;
      if (g_acc[i] !== 0 || vo[i] !== 0 || ov_o[i] !== 0 ||
          dv_o[i] !== 0 || dat_o[i] !== 0 || wt_o[i] !== 0) begin
        bad++;
        $display("FAIL async_rst inst%0d got=%0h/%b/%b/%b/%h/%h want all 0",
                 i, g_acc[i], vo[i], ov_o[i], dv_o[i],
                 dat_o[i], wt_o[i]);
      end
    end
    idle();
    #2 rst_n = 1;
    valid_in = 1; data_in = 8'd9;
    acc32 = 32'd1234; acc16 = 16'd1234;
    tick();
    total++;
    if (acc_o0 !== 32'd1234 || vo[0] !== 1'b1) begin
      bad++;
      $display("FAIL rst_zero_wt got=%0d/%b want=1234/1",
               acc_o0, vo[0]);
    end
    total++;
    if (vo[3] !== 1'b0) begin
      bad++;
      $display("FAIL rst_pipe_flush got=%b want=0", vo[3]);
    end
    idle();
    tick();
    total++;
    if (acc_o3 !== 32'd1234 || vo[3] !== 1'b1) begin
      bad++;
      $display("FAIL rst_pipe_zero_wt got=%0d/%b want=1234/1",
               acc_o3, vo[3]);
    end
  endtask

  initial begin
    test_reset();
    test_basic_mac();
    test_double_buffer();
    test_saturation();
    test_ovf_priority();
    test_pipe_gating();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
